// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified memory port
//                arbiter (FSM states, owner tag, request record).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int BE_W            = DATA_W / 8;
    localparam int MAX_DATA_STREAK = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              we;
    } mem_req_t;

    // A fetch is always a full-word read.
    function automatic mem_req_t fetch_req(input logic [ADDR_W-1:0] addr);
        mem_req_t r;
        r.addr  = addr;
        r.wdata = '0;
        r.be    = '1;
        r.we    = 1'b0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the IF-stage, MEM-stage and memory-side handshake
//                signals. slave = arbiter view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    // fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    // data port
    logic              dm_req_i;
    logic              dm_we_i;
    logic [BE_W-1:0]   dm_be_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;
    // memory port
    logic              mem_req_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_fetch_guard.sv
`default_nettype none
// ============================================================================
//  Module      : arb_fetch_guard
//  Description : Counts consecutive data grants taken while a fetch waits and
//                flags when the fetch must win the next arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_fetch_guard #(
    parameter int MAX_DATA_STREAK = mem_arb_pkg::MAX_DATA_STREAK
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic if_req_i,
    input  wire logic if_gnt_i,
    input  wire logic dm_gnt_i,
    output logic      force_if_o
);
    localparam int                 c_cnt_w = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_DATA_STREAK);

    logic [c_cnt_w-1:0] r_streak;

    // Streak of data grants over a pending fetch; saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_streak <= '0;
        end else if (!if_req_i || if_gnt_i) begin
            r_streak <= '0;
        end else if (dm_gnt_i && (r_streak != c_max)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    assign force_if_o = (r_streak == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between instruction fetch (IF) and
//                data access (MEM). One transaction in flight; data wins ties.
//                Optional anti-starvation guard: define ARB_FETCH_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    mem_port_arbiter_if.slave bus
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    mem_req_t   r_req;
    logic       r_mem_req;
    logic       r_post_rst;

    logic     w_force_if;
    logic     w_pick_dm;
    logic     w_in_req;
    logic     w_in_resp;
    logic     w_if_gnt;
    logic     w_dm_gnt;
    logic     w_if_rvalid;
    logic     w_dm_rvalid;
    mem_req_t w_dm_req;

`ifdef ARB_FETCH_GUARD_EN
    arb_fetch_guard #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_fetch_guard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .if_req_i   (bus.if_req_i),
        .if_gnt_i   (w_if_gnt),
        .dm_gnt_i   (w_dm_gnt),
        .force_if_o (w_force_if)
    );
`else
    assign w_force_if = 1'b0;
`endif

    // Data wins unless the guard says a waiting fetch has been passed over enough.
    assign w_pick_dm = bus.dm_req_i && !(w_force_if && bus.if_req_i);

    assign w_dm_req.addr  = bus.dm_addr_i;
    assign w_dm_req.wdata = bus.dm_wdata_i;
    assign w_dm_req.be    = bus.dm_be_i;
    assign w_dm_req.we    = bus.dm_we_i;

    // Request -> grant -> response sequencer with registered memory request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWN_IF;
            r_req     <= '0;
            r_mem_req <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (bus.dm_req_i || bus.if_req_i) begin
                        r_mem_req <= 1'b1;
                        r_state   <= ARB_REQ;
                        if (w_pick_dm) begin
                            r_owner <= OWN_DM;
                            r_req   <= w_dm_req;
                        end else begin
                            r_owner <= OWN_IF;
                            r_req   <= fetch_req(bus.if_addr_i);
                        end
                    end
                end
                ARB_REQ: begin
                    if (bus.mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (bus.mem_rvalid_i) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
            endcase
        end
    end

    // Marks the first clock after reset, when a stale response may still arrive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_post_rst <= 1'b1;
        end else begin
            r_post_rst <= 1'b0;
        end
    end

    assign w_in_req    = (r_state == ARB_REQ);
    assign w_in_resp   = (r_state == ARB_RESP);
    assign w_if_gnt    = w_in_req  && (r_owner == OWN_IF) && bus.mem_gnt_i;
    assign w_dm_gnt    = w_in_req  && (r_owner == OWN_DM) && bus.mem_gnt_i;
    assign w_if_rvalid = w_in_resp && (r_owner == OWN_IF) && bus.mem_rvalid_i;
    assign w_dm_rvalid = w_in_resp && (r_owner == OWN_DM) && bus.mem_rvalid_i;

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.dm_gnt_o    = w_dm_gnt;
    assign bus.if_rvalid_o = w_if_rvalid;
    assign bus.dm_rvalid_o = w_dm_rvalid;
    assign bus.if_rdata_o  = w_if_rvalid ? bus.mem_rdata_i : '0;
    assign bus.dm_rdata_o  = w_dm_rvalid ? bus.mem_rdata_i : '0;

    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_req.we;
    assign bus.mem_be_o    = r_req.be;
    assign bus.mem_addr_o  = r_req.addr;
    assign bus.mem_wdata_o = r_req.wdata;

    // Protocol checks: requests are held until granted; responses only when expected.
    a_if_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.if_req_i && !w_if_gnt) |=> bus.if_req_i);
    a_dm_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.dm_req_i && !w_dm_gnt) |=> bus.dm_req_i);
    a_rvalid_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.mem_rvalid_i && !r_post_rst) |-> w_in_resp);
    a_gnt_rvalid_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.mem_gnt_i && bus.mem_rvalid_i));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed vector bench for mem_port_arbiter: table of per-cycle
//                stimulus/expected outputs plus hand sequences for reset and
//                sustained-contention corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_if_gnt;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_dm_gnt;
        logic        e_dm_rvalid;
        logic [31:0] e_dm_rdata;
        logic        e_mem_req;
        logic        chk_f;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    logic clk_i;
    logic rst_ni;
    int   total;
    int   bad;
    vec_t vecs[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.dm_req_i     = 1'b0;
        bus.dm_we_i      = 1'b0;
        bus.dm_be_i      = '0;
        bus.dm_addr_i    = '0;
        bus.dm_wdata_i   = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.if_req_i     = v.if_req;
        bus.if_addr_i    = v.if_addr;
        bus.dm_req_i     = v.dm_req;
        bus.dm_we_i      = v.dm_we;
        bus.dm_be_i      = v.dm_be;
        bus.dm_addr_i    = v.dm_addr;
        bus.dm_wdata_i   = v.dm_wdata;
        bus.mem_gnt_i    = v.gnt;
        bus.mem_rvalid_i = v.rvalid;
        bus.mem_rdata_i  = v.rdata;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("if_gnt",    i, 32'(bus.if_gnt_o),    32'(v.e_if_gnt));
        chk("if_rvalid", i, 32'(bus.if_rvalid_o), 32'(v.e_if_rvalid));
        chk("if_rdata",  i, bus.if_rdata_o,       v.e_if_rdata);
        chk("dm_gnt",    i, 32'(bus.dm_gnt_o),    32'(v.e_dm_gnt));
        chk("dm_rvalid", i, 32'(bus.dm_rvalid_o), 32'(v.e_dm_rvalid));
        chk("dm_rdata",  i, bus.dm_rdata_o,       v.e_dm_rdata);
        chk("mem_req",   i, 32'(bus.mem_req_o),   32'(v.e_mem_req));
        if (v.chk_f) begin
            chk("mem_we",    i, 32'(bus.mem_we_o), 32'(v.e_we));
            chk("mem_be",    i, 32'(bus.mem_be_o), 32'(v.e_be));
            chk("mem_addr",  i, bus.mem_addr_o,    v.e_addr);
            chk("mem_wdata", i, bus.mem_wdata_o,   v.e_wdata);
        end
    endtask

    task automatic check_all_zero(input string nm, input int idx);
        chk({nm, "_if_gnt"},    idx, 32'(bus.if_gnt_o),    32'd0);
        chk({nm, "_if_rvalid"}, idx, 32'(bus.if_rvalid_o), 32'd0);
        chk({nm, "_if_rdata"},  idx, bus.if_rdata_o,       32'd0);
        chk({nm, "_dm_gnt"},    idx, 32'(bus.dm_gnt_o),    32'd0);
        chk({nm, "_dm_rvalid"}, idx, 32'(bus.dm_rvalid_o), 32'd0);
        chk({nm, "_dm_rdata"},  idx, bus.dm_rdata_o,       32'd0);
        chk({nm, "_mem_req"},   idx, 32'(bus.mem_req_o),   32'd0);
        chk({nm, "_mem_we"},    idx, 32'(bus.mem_we_o),    32'd0);
        chk({nm, "_mem_be"},    idx, 32'(bus.mem_be_o),    32'd0);
        chk({nm, "_mem_addr"},  idx, bus.mem_addr_o,       32'd0);
        chk({nm, "_mem_wdata"}, idx, bus.mem_wdata_o,      32'd0);
    endtask

    initial begin
        logic       grants[8];
        int         ngr;
        int         nif;
        logic       pend;
        logic       exp_g;

        total = 0;
        bad   = 0;

        // ---------------- vector table ----------------
        // Test 1: fetch only
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, default:'0});
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, gnt:1'b1, e_if_gnt:1'b1, e_mem_req:1'b1,
                         chk_f:1'b1, e_be:4'hF, e_addr:32'h10, default:'0});
        vecs.push_back('{rvalid:1'b1, rdata:32'h0050_0093, e_if_rvalid:1'b1,
                         e_if_rdata:32'h0050_0093, default:'0});
        vecs.push_back('{default:'0});
        // Test 2: simultaneous fetch and load, data first
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, dm_req:1'b1, dm_be:4'hF, dm_addr:32'h100, default:'0});
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, dm_req:1'b1, dm_be:4'hF, dm_addr:32'h100, gnt:1'b1,
                         e_dm_gnt:1'b1, e_mem_req:1'b1, chk_f:1'b1, e_be:4'hF, e_addr:32'h100, default:'0});
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, rvalid:1'b1, rdata:32'h1111_2222,
                         e_dm_rvalid:1'b1, e_dm_rdata:32'h1111_2222, default:'0});
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, default:'0});
        vecs.push_back('{if_req:1'b1, if_addr:32'h10, gnt:1'b1, e_if_gnt:1'b1, e_mem_req:1'b1,
                         chk_f:1'b1, e_be:4'hF, e_addr:32'h10, default:'0});
        vecs.push_back('{rvalid:1'b1, rdata:32'h3333_4444, e_if_rvalid:1'b1,
                         e_if_rdata:32'h3333_4444, default:'0});
        // Test 3: store with partial byte enables
        vecs.push_back('{dm_req:1'b1, dm_we:1'b1, dm_be:4'b0011, dm_addr:32'h104,
                         dm_wdata:32'hDEAD_BEEF, default:'0});
        vecs.push_back('{dm_req:1'b1, dm_we:1'b1, dm_be:4'b0011, dm_addr:32'h104,
                         dm_wdata:32'hDEAD_BEEF, gnt:1'b1, e_dm_gnt:1'b1, e_mem_req:1'b1, chk_f:1'b1,
                         e_we:1'b1, e_be:4'b0011, e_addr:32'h104, e_wdata:32'hDEAD_BEEF, default:'0});
        vecs.push_back('{rvalid:1'b1, rdata:32'h0, e_dm_rvalid:1'b1, default:'0});
        // Test 4: memory stalls the grant for 5 cycles
        vecs.push_back('{dm_req:1'b1, dm_be:4'hF, dm_addr:32'h200, default:'0});
        for (int k = 0; k < 5; k++) begin
            vecs.push_back('{dm_req:1'b1, dm_be:4'hF, dm_addr:32'h200, e_mem_req:1'b1,
                             chk_f:1'b1, e_be:4'hF, e_addr:32'h200, default:'0});
        end
        vecs.push_back('{dm_req:1'b1, dm_be:4'hF, dm_addr:32'h200, gnt:1'b1, e_dm_gnt:1'b1,
                         e_mem_req:1'b1, chk_f:1'b1, e_be:4'hF, e_addr:32'h200, default:'0});
        vecs.push_back('{rvalid:1'b1, rdata:32'hCAFE_0001, e_dm_rvalid:1'b1,
                         e_dm_rdata:32'hCAFE_0001, default:'0});
        vecs.push_back('{default:'0});

        // ---------------- reset state ----------------
        drive_idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset", 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clk_i);
            check_vec(i, vecs[i]);
            @(posedge clk_i);
            #1;
        end

        // ---------------- Test 5: async reset during response phase ----------------
        drive_idle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        @(posedge clk_i);
        #1;
        bus.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t5_if_gnt", 0, 32'(bus.if_gnt_o), 32'd1);
        @(posedge clk_i);
        #1;
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b0;
        #1;
        chk("t5_pre_rvalid", 1, 32'(bus.if_rvalid_o), 32'd0);
        rst_ni            = 1'b0;
        bus.mem_rvalid_i  = 1'b1;
        bus.mem_rdata_i   = 32'hAAAA_5555;
        #1;
        check_all_zero("t5_rst", 2);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t5_late_if_rvalid", 3, 32'(bus.if_rvalid_o), 32'd0);
        chk("t5_late_dm_rvalid", 3, 32'(bus.dm_rvalid_o), 32'd0);
        chk("t5_late_mem_req",   3, 32'(bus.mem_req_o),   32'd0);
        @(posedge clk_i);
        #1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.if_req_i     = 1'b1;
        bus.if_addr_i    = 32'h44;
        @(negedge clk_i);
        chk("t5_idle_mem_req", 4, 32'(bus.mem_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        bus.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("t5_req_mem_req",  5, 32'(bus.mem_req_o), 32'd1);
        chk("t5_req_mem_addr", 5, bus.mem_addr_o,     32'h44);
        chk("t5_req_if_gnt",   5, 32'(bus.if_gnt_o),  32'd1);
        @(posedge clk_i);
        #1;
        bus.if_req_i     = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0013;
        @(negedge clk_i);
        chk("t5_if_rvalid", 6, 32'(bus.if_rvalid_o), 32'd1);
        chk("t5_if_rdata",  6, bus.if_rdata_o,       32'h0000_0013);
        @(posedge clk_i);
        #1;
        drive_idle();

        // ---------------- Test 6: sustained contention ----------------
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h50;
        bus.dm_req_i  = 1'b1;
        bus.dm_be_i   = 4'hF;
        bus.dm_addr_i = 32'h300;
        ngr  = 0;
        nif  = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 60 && ngr < 8; cyc++) begin
            bus.mem_rvalid_i = pend;
            bus.mem_rdata_i  = 32'h0;
            bus.mem_gnt_i    = bus.mem_req_o;
            pend             = bus.mem_req_o;
            @(negedge clk_i);
            if (bus.dm_gnt_o && ngr < 8) begin
                grants[ngr] = 1'b0;
                ngr++;
            end
            if (bus.if_gnt_o && ngr < 8) begin
                grants[ngr] = 1'b1;
                ngr++;
                nif++;
            end
            @(posedge clk_i);
            #1;
        end
        chk("t6_grant_count", 0, 32'(ngr), 32'd8);
        for (int i = 0; i < ngr; i++) begin
`ifdef ARB_FETCH_GUARD_EN
            exp_g = (i == 4);
`else
            exp_g = 1'b0;
`endif
            chk("t6_grant_is_if", i, 32'(grants[i]), 32'(exp_g));
        end
`ifdef ARB_FETCH_GUARD_EN
        chk("t6_if_grants", 1, 32'(nif), 32'd1);
`else
        chk("t6_if_grants", 1, 32'(nif), 32'd0);
`endif

        // Abandon the outstanding requests under reset.
        rst_ni = 1'b0;
        drive_idle();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
